// File: rtl/ttl_shift_store_reg.sv
// ttl_shift_store_reg: sampled-pin shift/storage register with bidirectional shift, load, cascade and event count; TTL_SHIFT_STORE_SYNC_EN adds 2-flop pin synchronisers
module ttl_shift_store_reg #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_srck,
  input  logic             i_rck,
  input  logic             i_sclr_n,
  input  logic [1:0]       i_mode,
  input  logic             i_ser_up,
  input  logic             i_ser_dn,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_oe_n,
  output logic [WIDTH-1:0] o_q,
  output logic [WIDTH-1:0] o_q_oe,
  output logic             o_cas_up,
  output logic             o_cas_dn,
  output logic [CW-1:0]    o_shift_cnt,
  output logic             o_full
);
  localparam logic [CW-1:0] MAX = CW'(WIDTH);
  logic [2:0]       r_s;
  logic [1:0]       r_p;
  logic [WIDTH-1:0] r_shift, r_store, w_mux, w_shift_nxt, w_store_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_base, w_cnt_nxt;
  logic             r_full, w_srck_fall, w_rck_fall;
`ifdef TTL_SHIFT_STORE_SYNC_EN
  logic [2:0]       r_m;
  // two-flop synchroniser for {sclr_n, rck, srck}; sclr_n rests high
  always_ff @(posedge i_clk)
    if (!i_rst_n) begin
      r_m <= 3'b100;
      r_s <= 3'b100;
    end else begin
      r_m <= {i_sclr_n, i_rck, i_srck};
      r_s <= r_m;
    end
`else
  // single sample flop for {sclr_n, rck, srck}; sclr_n rests high
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_s <= 3'b100;
    else r_s <= {i_sclr_n, i_rck, i_srck};
`endif
  // previous sampled level; zero after reset so a low pin never looks like a fall
  always_ff @(posedge i_clk)
    if (!i_rst_n) r_p <= '0;
    else r_p <= r_s[1:0];
  assign w_srck_fall = r_p[0] & ~r_s[0];
  assign w_rck_fall  = r_p[1] & ~r_s[1];
  assign w_mux = i_mode == 2'b01 ? {r_shift[WIDTH-2:0], i_ser_up} :
                 i_mode == 2'b10 ? {i_ser_dn, r_shift[WIDTH-1:1]} :
                 i_mode == 2'b11 ? i_d : r_shift;
  assign w_shift_nxt = w_srck_fall ? w_mux : r_shift;
  assign w_store_nxt = w_rck_fall ? r_shift : r_store;
  assign w_cnt_base  = w_rck_fall ? '0 : r_cnt;
  assign w_cnt_nxt   = (w_srck_fall && |i_mode && w_cnt_base != MAX) ? w_cnt_base + CW'(1) : w_cnt_base;
  // register state; a held clear wipes everything and swallows events
  always_ff @(posedge i_clk)
    if (!i_rst_n || !r_s[2]) begin
      r_shift <= '0;
      r_store <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_store <= w_store_nxt;
      r_cnt   <= w_cnt_nxt;
      r_full  <= w_cnt_nxt == MAX;
    end
  assign o_q         = r_store;
  assign o_q_oe      = {WIDTH{~i_oe_n}};
  assign o_cas_up    = r_shift[WIDTH-1];
  assign o_cas_dn    = r_shift[0];
  assign o_shift_cnt = r_cnt;
  assign o_full      = r_full;
endmodule
